// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiply / multiply-accumulate (MUL/MLA).
// It takes one multiplier bit per cycle. Result, tag and flags are registered.
// They update only on the finishing edge, so they stay stable for writeback.
module mul_unit #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Accumulate,
    input  logic [WIDTH-1:0] Rm,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Acc,
    input  logic [3:0]       RdIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       RdOut,
    output logic             N,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, q_q, p_q;
    logic [CW-1:0]    count_q;
    logic [3:0]       rd_q;

    logic [WIDTH-1:0] p_next, q_next;
    logic             accept, last, finish;

    // State register; reset wins over everything, including Start
    always_ff @(posedge clk) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: IDLE -> RUN on Start, RUN -> IDLE on the final iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start)  state_d = RUN;
            RUN:     if (finish) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Iteration decode: the next partial sum and whether this step is the last one
    always_comb begin
        p_next = q_q[0] ? (p_q + m_q) : p_q;   // carry out dropped, mod 2^WIDTH
        q_next = q_q >> 1;
        last   = (count_q == CW'(WIDTH - 1)) ||
                 ((EARLY_EXIT != 0) && (q_next == '0));
        accept = (state_q == IDLE) && Start;
        finish = (state_q == RUN) && last;
    end

    // Operand capture on accept, then one shift-add step per RUN cycle
    always_ff @(posedge clk) begin
        if (!Reset) begin
            m_q     <= '0;
            q_q     <= '0;
            p_q     <= '0;
            count_q <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            m_q     <= Rm;
            q_q     <= Rs;
            p_q     <= Accumulate ? Acc : '0;
            count_q <= '0;
            rd_q    <= RdIn;
        end else if (state_q == RUN) begin
            m_q     <= m_q << 1;
            q_q     <= q_next;
            p_q     <= p_next;
            count_q <= count_q + CW'(1);
        end
    end

    // Registered outputs. The writeback fields change only when an operation completes.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Result <= '0;
            RdOut  <= '0;
            N      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            Busy <= (state_d == RUN);
            Done <= finish;
            if (finish) begin
                Result <= p_next;
                RdOut  <= rd_q;
                N      <= p_next[WIDTH-1];
                Z      <= (p_next == '0);
            end
        end
    end

endmodule
